// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event front end: event kinds and the
// packed event layout used in the event FIFO.
package keypad_pkg;

    localparam int EV_IDX_W = 4;

    localparam logic EV_PRESS   = 1'b0;
    localparam logic EV_RELEASE = 1'b1;

    typedef struct packed {
        logic                kind;
        logic [EV_IDX_W-1:0] index;
    } key_event_t;

endpackage

// File: rtl/key_debounce.sv
// One key: registers the raw level, counts consecutive cycles where the
// sample disagrees with the debounced level, and commits the new level
// (with a one-cycle change strobe) on the DEBOUNCE-th disagreeing cycle.
module key_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic stable_o,
    output logic change_o
);
    localparam int CNT_W = $clog2(DEBOUNCE) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             r_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter restarts on agreement; the last disagreeing cycle flips the level.
    always_comb begin
        change_o = (r_q != stable_q) && (cnt_q == CNT_LAST);
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (r_q == stable_q) begin
            cnt_d = '0;
        end else if (change_o) begin
            stable_d = r_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Sample register, debounced level and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            r_q      <= level_i;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/keypad_events.sv
// Keypad front end: per-key debounce, held-key priority index, release
// trigger for the wait-for-key path, and an event FIFO fed from one pending
// slot per key through a lowest-index-first arbiter.
module keypad_events
    import keypad_pkg::*;
#(
    parameter int N_KEYS     = 16,
    parameter int IDX_W      = 4,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keypad_matrix,
    output logic [N_KEYS-1:0] keys_stable,
    output logic              any_held,
    output logic [IDX_W-1:0]  held_index,
    output logic              release_trigger,
    output logic [IDX_W-1:0]  release_index,
    output logic              ev_valid,
    output logic [IDX_W-1:0]  ev_index,
    output logic              ev_release,
    input  logic              ev_ready,
    output logic              ev_overflow,
    input  logic              clr_overflow
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    logic [N_KEYS-1:0] chg;
    logic [N_KEYS-1:0] pend_q, pend_d, pend_rel_q, pend_rel_d, drain;
    logic              sel_found, sel_kind, loss;
    logic [IDX_W-1:0]  sel_idx;
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic              empty, full, push, pop;
    logic [IDX_W:0]    mem_q [FIFO_DEPTH];
    logic              ovf_q, ovf_d, any_q, trig_d, trig_q;
    logic [IDX_W-1:0]  held_q, held_d, ridx_q, ridx_d;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk      (clk),
            .reset    (reset),
            .level_i  (keypad_matrix[k]),
            .stable_o (keys_stable[k]),
            .change_o (chg[k])
        );
    end

    assign any_held = |keys_stable;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop      = !empty && ev_ready;
    assign push     = sel_found && (!full || pop);
    assign ev_valid = !empty;
    assign {ev_release, ev_index} = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    // Arbiter: lowest-index occupied slot (descending scan, last hit wins).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_kind  = EV_PRESS;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (pend_q[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
                sel_kind  = pend_rel_q[k];
            end
        end
    end

    // Slot update: drain the pushed slot, accept new edges unless the slot is still busy.
    always_comb begin
        pend_d     = pend_q;
        pend_rel_d = pend_rel_q;
        drain      = '0;
        loss       = 1'b0;
        for (int k = 0; k < N_KEYS; k++) begin
            drain[k] = push && (sel_idx == IDX_W'(k));
            if (drain[k]) pend_d[k] = 1'b0;
            if (chg[k]) begin
                if (pend_q[k] && !drain[k]) begin
                    loss = 1'b1;
                end else begin
                    pend_d[k]     = 1'b1;
                    pend_rel_d[k] = keys_stable[k] ? EV_RELEASE : EV_PRESS;
                end
            end
        end
        ovf_d = loss ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
    end

    // Held-key priority encode (highest wins, hold when idle) and release detect.
    always_comb begin
        held_d = held_q;
        for (int k = 0; k < N_KEYS; k++) begin
            if (keys_stable[k]) held_d = IDX_W'(k);
        end
        trig_d = any_q && !any_held;
        ridx_d = trig_d ? held_q : ridx_q;
    end

    // Control state: slots, pointers, sticky overflow, held/release registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '0;
            pend_rel_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ovf_q      <= 1'b0;
            any_q      <= 1'b0;
            trig_q     <= 1'b0;
            held_q     <= '0;
            ridx_q     <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_rel_q <= pend_rel_d;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            ovf_q      <= ovf_d;
            any_q      <= any_held;
            trig_q     <= trig_d;
            held_q     <= held_d;
            ridx_q     <= ridx_d;
        end
    end

    // Event storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= {sel_kind, sel_idx};
    end

    assign ev_overflow     = ovf_q;
    assign held_index      = held_q;
    assign release_trigger = trig_q;
    assign release_index   = ridx_q;

endmodule

// File: tb/tb_keypad_events.sv
// Bench for keypad_events: directed scenarios plus a randomized run checked
// against a queue-based behavioural model of the keypad event path.
module tb_keypad_events;
    localparam int NK = 16;
    localparam int IW = 4;
    localparam int DB = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keypad_matrix = '0;
    logic [NK-1:0] keys_stable;
    logic          any_held;
    logic [IW-1:0] held_index;
    logic          release_trigger;
    logic [IW-1:0] release_index;
    logic          ev_valid;
    logic [IW-1:0] ev_index;
    logic          ev_release;
    logic          ev_ready = 1'b0;
    logic          ev_overflow;
    logic          clr_overflow = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keypad_events #(.N_KEYS(NK), .IDX_W(IW), .DEBOUNCE(DB), .FIFO_DEPTH(FD)) dut (
        .clk             (clk),
        .reset           (reset),
        .keypad_matrix   (keypad_matrix),
        .keys_stable     (keys_stable),
        .any_held        (any_held),
        .held_index      (held_index),
        .release_trigger (release_trigger),
        .release_index   (release_index),
        .ev_valid        (ev_valid),
        .ev_index        (ev_index),
        .ev_release      (ev_release),
        .ev_ready        (ev_ready),
        .ev_overflow     (ev_overflow),
        .clr_overflow    (clr_overflow)
    );

    // Behavioural model: a stable level flips once the last DB samples all
    // disagree with it; events go into per-key slots, then into a queue.
    logic [NK-1:0] m_r, m_stable, m_pend, m_prel;
    logic [NK-1:0] hist[$];
    logic [IW:0]   mq[$];
    logic [IW-1:0] m_held, m_ridx;
    logic          m_trig, m_prev_any, m_ovf;

    task automatic model_step();
        logic [NK-1:0] flip, np, nr;
        int  sel;
        bit  pop, push, loss, any;
        if (reset) begin
            m_r = '0; m_stable = '0; m_pend = '0; m_prel = '0;
            m_held = '0; m_ridx = '0; m_trig = 0; m_prev_any = 0; m_ovf = 0;
            hist.delete(); mq.delete();
            return;
        end
        hist.push_back(m_r);
        if (hist.size() > DB) void'(hist.pop_front());
        flip = '0;
        if (hist.size() == DB) begin
            for (int k = 0; k < NK; k++) begin
                bit all_diff;
                all_diff = 1;
                foreach (hist[i]) if (hist[i][k] == m_stable[k]) all_diff = 0;
                flip[k] = all_diff;
            end
        end
        pop = (mq.size() > 0) && ev_ready;
        sel = -1;
        for (int k = NK - 1; k >= 0; k--) if (m_pend[k]) sel = k;
        push = (sel >= 0) && ((mq.size() < FD) || pop);
        np = m_pend; nr = m_prel; loss = 0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back({m_prel[sel], IW'(sel)});
            np[sel] = 1'b0;
        end
        for (int k = 0; k < NK; k++) begin
            if (flip[k]) begin
                if (m_pend[k] && !(push && sel == k)) loss = 1;
                else begin np[k] = 1'b1; nr[k] = m_stable[k]; end
            end
        end
        any = (m_stable != 0);
        m_trig = m_prev_any && !any;
        if (m_trig) m_ridx = m_held;
        for (int k = 0; k < NK; k++) if (m_stable[k]) m_held = IW'(k);
        m_prev_any = any;
        m_ovf = loss ? 1'b1 : (clr_overflow ? 1'b0 : m_ovf);
        m_pend = np; m_prel = nr;
        m_stable = m_stable ^ flip;
        m_r = keypad_matrix;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; keypad_matrix = '0; ev_ready = 0; clr_overflow = 0;
        tick(); tick();
        total++; if (keys_stable !== '0) begin bad++; $display("FAIL reset_stable: got %0h want 0", keys_stable); end
        total++; if (any_held !== 1'b0) begin bad++; $display("FAIL reset_any: got %0b want 0", any_held); end
        total++; if (held_index !== '0) begin bad++; $display("FAIL reset_held: got %0d want 0", held_index); end
        total++; if (release_trigger !== 1'b0) begin bad++; $display("FAIL reset_trig: got %0b want 0", release_trigger); end
        total++; if (release_index !== '0) begin bad++; $display("FAIL reset_ridx: got %0d want 0", release_index); end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", ev_valid); end
        total++; if ({ev_release, ev_index} !== '0) begin bad++; $display("FAIL reset_head: got %0h want 0", {ev_release, ev_index}); end
        total++; if (ev_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", ev_overflow); end
        reset = 0;
    endtask

    task automatic test_single_key();
        int trig_cnt, ridx, nev;
        logic [IW:0] ev0;
        ev_ready = 1; keypad_matrix = 16'h0020;
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (e == 4) begin
                total++; if (keys_stable !== 16'h0020) begin bad++; $display("FAIL single_stable: got %0h want 20", keys_stable); end
                total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %0b want 0", ev_valid); end
            end
            if (e == 5) begin
                total++; if ({ev_valid, ev_release, ev_index} !== {1'b1, 1'b0, 4'd5}) begin
                    bad++; $display("FAIL single_press: got v=%0b k=%0b i=%0d want v=1 k=0 i=5", ev_valid, ev_release, ev_index); end
                total++; if (held_index !== 4'd5) begin bad++; $display("FAIL single_held: got %0d want 5", held_index); end
            end
        end
        for (int i = 0; i < 14; i++) tick();
        keypad_matrix = '0;
        trig_cnt = 0; ridx = -1; nev = 0; ev0 = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (release_trigger) begin trig_cnt++; ridx = int'(release_index); end
            if (ev_valid) begin if (nev == 0) ev0 = {ev_release, ev_index}; nev++; end
        end
        total++; if (trig_cnt != 1) begin bad++; $display("FAIL single_trig_count: got %0d want 1", trig_cnt); end
        total++; if (ridx != 5) begin bad++; $display("FAIL single_ridx: got %0d want 5", ridx); end
        total++; if (nev != 1 || ev0 !== {1'b1, 4'd5}) begin
            bad++; $display("FAIL single_release_ev: got n=%0d ev=%0h want n=1 ev=15", nev, ev0); end
    endtask

    task automatic test_glitch();
        int nvalid, nstable;
        nvalid = 0; nstable = 0;
        keypad_matrix = 16'h0008;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) keypad_matrix = '0;
            tick();
            if (ev_valid) nvalid++;
            if (keys_stable != 0) nstable++;
        end
        total++; if (nstable != 0) begin bad++; $display("FAIL glitch_stable: got %0d cycles want 0", nstable); end
        total++; if (nvalid != 0) begin bad++; $display("FAIL glitch_event: got %0d cycles want 0", nvalid); end
    endtask

    task automatic test_simultaneous();
        logic [IW-1:0] exp_i [3];
        exp_i[0] = 4'd2; exp_i[1] = 4'd9; exp_i[2] = 4'd14;
        ev_ready = 1; keypad_matrix = 16'h4204;
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e >= 5) begin
                total++; if ({ev_valid, ev_release, ev_index} !== {1'b1, 1'b0, exp_i[e-5]}) begin
                    bad++; $display("FAIL simul_ev%0d: got v=%0b k=%0b i=%0d want v=1 k=0 i=%0d", e-5, ev_valid, ev_release, ev_index, exp_i[e-5]); end
            end
        end
        total++; if (held_index !== 4'd14) begin bad++; $display("FAIL simul_held: got %0d want 14", held_index); end
        keypad_matrix = '0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_backpressure();
        logic [IW:0] got[$];
        ev_ready = 0; keypad_matrix = 16'h003F;
        for (int i = 0; i < 12; i++) tick();
        total++; if ({ev_valid, ev_release, ev_index, ev_overflow} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            bad++; $display("FAIL bp_full_head: got v=%0b k=%0b i=%0d o=%0b want v=1 k=0 i=0 o=0", ev_valid, ev_release, ev_index, ev_overflow); end
        keypad_matrix = 16'h002F;
        for (int i = 0; i < 6; i++) tick();
        total++; if (ev_overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow: got %0b want 1", ev_overflow); end
        total++; if (keys_stable !== 16'h002F) begin bad++; $display("FAIL bp_stable: got %0h want 2f", keys_stable); end
        ev_ready = 1;
        for (int i = 0; i < 8; i++) begin
            if (ev_valid) got.push_back({ev_release, ev_index});
            tick();
        end
        total++; if (got.size() != 6) begin bad++; $display("FAIL bp_drain_count: got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            total++; if (got[i] !== {1'b0, IW'(i)}) begin bad++; $display("FAIL bp_drain%0d: got %0h want %0h", i, got[i], {1'b0, IW'(i)}); end
        end
        clr_overflow = 1; tick(); clr_overflow = 0;
        total++; if (ev_overflow !== 1'b0) begin bad++; $display("FAIL bp_clear: got %0b want 0", ev_overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [IW:0] got[$];
        ev_ready = 1; keypad_matrix = '0;
        for (int i = 0; i < 15; i++) tick();
        ev_ready = 0; keypad_matrix = 16'h00F8;
        for (int i = 0; i < 12; i++) tick();
        total++; if ({ev_valid, ev_index} !== {1'b1, 4'd3}) begin
            bad++; $display("FAIL fpp_head_before: got v=%0b i=%0d want v=1 i=3", ev_valid, ev_index); end
        ev_ready = 1; tick(); ev_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        total++; if ({ev_valid, ev_index, ev_overflow} !== {1'b1, 4'd4, 1'b0}) begin
            bad++; $display("FAIL fpp_head_after: got v=%0b i=%0d o=%0b want v=1 i=4 o=0", ev_valid, ev_index, ev_overflow); end
        ev_ready = 1;
        for (int i = 0; i < 8; i++) begin
            if (ev_valid) got.push_back({ev_release, ev_index});
            tick();
        end
        total++; if (got.size() != 4) begin bad++; $display("FAIL fpp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++; if (got[i] !== {1'b0, IW'(i + 4)}) begin bad++; $display("FAIL fpp_ev%0d: got %0h want %0h", i, got[i], {1'b0, IW'(i + 4)}); end
        end
        keypad_matrix = '0;
        for (int i = 0; i < 15; i++) tick();
    endtask

    task automatic test_reset_midstream();
        ev_ready = 0; keypad_matrix = 16'h0006;
        for (int i = 0; i < 12; i++) tick();
        total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %0b want 1", ev_valid); end
        keypad_matrix = 16'h0002;
        reset = 1; tick(); reset = 0;
        total++; if ({ev_valid, keys_stable} !== {1'b0, 16'h0}) begin
            bad++; $display("FAIL rst_cleared: got v=%0b s=%0h want v=0 s=0", ev_valid, keys_stable); end
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 6) begin
                total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL rst_early%0d: got %0b want 0", e, ev_valid); end
            end else begin
                total++; if ({ev_valid, ev_release, ev_index} !== {1'b1, 1'b0, 4'd1}) begin
                    bad++; $display("FAIL rst_repress: got v=%0b k=%0b i=%0d want v=1 k=0 i=1", ev_valid, ev_release, ev_index); end
            end
        end
        ev_ready = 1; keypad_matrix = '0;
        for (int i = 0; i < 15; i++) tick();
    endtask

    task automatic test_random();
        int seg;
        logic [IW:0] head;
        seg = 0;
        for (int c = 0; c < 1500; c++) begin
            if (seg == 0) begin
                keypad_matrix = keypad_matrix ^ (NK'(1) << $urandom_range(0, NK - 1));
                if ($urandom_range(0, 2) == 0) keypad_matrix = keypad_matrix ^ (NK'(1) << $urandom_range(0, NK - 1));
                seg = $urandom_range(1, 10);
            end
            seg--;
            ev_ready     = ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            reset        = ($urandom_range(0, 299) == 0);
            tick();
            head = (mq.size() > 0) ? mq[0] : '0;
            total++; if (keys_stable !== m_stable) begin bad++; $display("FAIL rnd_stable c%0d: got %0h want %0h", c, keys_stable, m_stable); end
            total++; if (any_held !== (m_stable != 0)) begin bad++; $display("FAIL rnd_any c%0d: got %0b want %0b", c, any_held, m_stable != 0); end
            total++; if (held_index !== m_held) begin bad++; $display("FAIL rnd_held c%0d: got %0d want %0d", c, held_index, m_held); end
            total++; if (release_trigger !== m_trig) begin bad++; $display("FAIL rnd_trig c%0d: got %0b want %0b", c, release_trigger, m_trig); end
            total++; if (release_index !== m_ridx) begin bad++; $display("FAIL rnd_ridx c%0d: got %0d want %0d", c, release_index, m_ridx); end
            total++; if (ev_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, ev_valid, mq.size() > 0); end
            total++; if ({ev_release, ev_index} !== head) begin bad++; $display("FAIL rnd_head c%0d: got %0h want %0h", c, {ev_release, ev_index}, head); end
            total++; if (ev_overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf c%0d: got %0b want %0b", c, ev_overflow, m_ovf); end
        end
        reset = 0; clr_overflow = 0;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_glitch();
        test_simultaneous();
        test_backpressure();
        test_full_push_pop();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
